// File: rtl/mac_crc_engine.sv
// ============================================================================
// mac_crc_engine
// ----------------------------------------------------------------------------
// Streaming Ethernet CRC-32 engine. Frames arrive as beats of DATA_BYTES
// bytes (byte 0 first on the wire). In generate mode the frame FCS is
// produced; in check mode the frame already carries its FCS and the engine
// flags whether the CRC register lands on the Ethernet residue. One result is
// produced per frame, and per-frame statistics are kept in saturating
// counters.
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A valid
// side holds its payload stable until the transfer; in_ready depends
// combinationally on out_valid/out_ready only, never on in_valid.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input beat handshake
//   in_data           beat bytes, byte 0 = in_data[7:0]
//   in_keep           per-byte valid, only looked at on the last beat
//   in_last           last beat of the frame
//   check_mode        0 = generate, 1 = check; taken from the first beat
//   out_valid/ready   result handshake
//   crc_out           final CRC (register XOR all-ones)
//   crc_match         check-mode pass flag
//   protocol_err      last beat carried an illegal in_keep
//   frame_cnt         completed frames (saturating)
//   crc_err_cnt       failed check-mode frames (saturating)
//   dbg_state         FSM state (0 = IDLE, 1 = ACCUM, 2 = DONE)
// ============================================================================
module mac_crc_engine #(
    parameter int DATA_BYTES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    input  logic                    check_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             crc_out,
    output logic                    crc_match,
    output logic                    protocol_err,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        crc_err_cnt,
    output logic [1:0]              dbg_state
);

    localparam logic [31:0]      POLY    = 32'hEDB88320;
    localparam logic [31:0]      SEED    = 32'hFFFFFFFF;
    localparam logic [31:0]      RESIDUE = 32'hDEBB20E3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_crc;
    logic                  r_mode;
    logic                  r_out_valid;
    logic [31:0]           r_crc_out;
    logic                  r_crc_match;
    logic                  r_protocol_err;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic [CNT_W-1:0]      r_crc_err_cnt;

    logic                  w_accept;
    logic                  w_mode;
    logic                  w_run;
    logic                  w_keep_bad;
    logic                  w_match;
    logic [DATA_BYTES-1:0] w_incl;
    logic [31:0]           w_crc_next;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Mode is captured on the first beat; later beats reuse the latched copy.
    assign w_mode = (r_state == ST_ACCUM) ? r_mode : check_mode;

    // Byte inclusion: every byte on non-last beats; on the last beat only the
    // leading run of ones in in_keep. Anything other than a non-empty leading
    // run (zero, or holes) is reported as a protocol error.
    always_comb begin : keep_decode
        w_incl     = '1;
        w_run      = 1'b1;
        w_keep_bad = 1'b0;
        if (in_last) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                w_run     = w_run & in_keep[i];
                w_incl[i] = w_run;
            end
            w_keep_bad = (w_incl != in_keep) || !in_keep[0];
        end
    end

    // Bit-serial reflected CRC unrolled over all included bytes of the beat.
    always_comb begin : crc_comb
        w_crc_next = r_crc;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (w_incl[b]) begin
                for (int i = 0; i < 8; i++) begin
                    if (w_crc_next[0] ^ in_data[8*b+i]) begin
                        w_crc_next = (w_crc_next >> 1) ^ POLY;
                    end else begin
                        w_crc_next = w_crc_next >> 1;
                    end
                end
            end
        end
    end

    assign w_match = w_mode && (w_crc_next == RESIDUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_crc          <= SEED;
            r_mode         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_crc_out      <= 32'h0;
            r_crc_match    <= 1'b0;
            r_protocol_err <= 1'b0;
            r_frame_cnt    <= '0;
            r_crc_err_cnt  <= '0;
        end else begin
            // A consumed result drops out_valid unless a new one lands below.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_mode <= w_mode;
                if (in_last) begin
                    r_state        <= ST_DONE;
                    // Re-seed right away so the next frame can start next cycle.
                    r_crc          <= SEED;
                    r_out_valid    <= 1'b1;
                    r_crc_out      <= w_crc_next ^ SEED;
                    r_crc_match    <= w_match;
                    r_protocol_err <= w_keep_bad;
                    if (r_frame_cnt != '1) begin
                        r_frame_cnt <= r_frame_cnt + CNT_ONE;
                    end
                    if (w_mode && !w_match && (r_crc_err_cnt != '1)) begin
                        r_crc_err_cnt <= r_crc_err_cnt + CNT_ONE;
                    end
                end else begin
                    r_state <= ST_ACCUM;
                    r_crc   <= w_crc_next;
                end
            end else if ((r_state == ST_DONE) && out_ready) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign crc_out      = r_crc_out;
    assign crc_match    = r_crc_match;
    assign protocol_err = r_protocol_err;
    assign frame_cnt    = r_frame_cnt;
    assign crc_err_cnt  = r_crc_err_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mac_crc_engine.sv
// ============================================================================
// tb_mac_crc_engine
// ----------------------------------------------------------------------------
// Two engines share clock and reset: u1 with DATA_BYTES = 1 (default
// counters) and u4 with DATA_BYTES = 4 and 3-bit counters so saturation is
// reachable. Expected results are computed from a reference CRC-32 and
// pushed to a per-engine queue when a frame is driven; they are popped and
// compared whenever the engine hands over a result.
// ============================================================================
`timescale 1ns/1ps
module tb_mac_crc_engine;

    localparam logic [31:0] SEED    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam int          MAX4    = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- u1 (1 byte / beat) ----------------
    logic        v1 = 1'b0, l1 = 1'b0, m1 = 1'b0, ordy1 = 1'b1;
    logic [7:0]  d1 = 8'h0;
    logic [0:0]  k1 = 1'b1;
    logic        rdy1, ov1, cm1, pe1;
    logic [31:0] crc1;
    logic [15:0] fc1, ec1;
    logic [1:0]  st1;

    // ---------------- u4 (4 bytes / beat) ----------------
    logic        v4 = 1'b0, l4 = 1'b0, m4 = 1'b0, ordy4 = 1'b1;
    logic [31:0] d4 = 32'h0;
    logic [3:0]  k4 = 4'h0;
    logic        rdy4, ov4, cm4, pe4;
    logic [31:0] crc4;
    logic [2:0]  fc4, ec4;
    logic [1:0]  st4;

    mac_crc_engine #(.DATA_BYTES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_keep(k1), .in_last(l1), .check_mode(m1), .out_valid(ov1),
        .out_ready(ordy1), .crc_out(crc1), .crc_match(cm1), .protocol_err(pe1),
        .frame_cnt(fc1), .crc_err_cnt(ec1), .dbg_state(st1)
    );

    mac_crc_engine #(.DATA_BYTES(4), .CNT_W(3)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .in_keep(k4), .in_last(l4), .check_mode(m4), .out_valid(ov4),
        .out_ready(ordy4), .crc_out(crc4), .crc_match(cm4), .protocol_err(pe4),
        .frame_cnt(fc4), .crc_err_cnt(ec4), .dbg_state(st4)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] exp1_q[$];   // {crc_out, crc_match, protocol_err}
    logic [33:0] exp4_q[$];
    logic [7:0]  fb[$];       // bytes of the frame about to be sent
    int          m_fc1 = 0, m_ec1 = 0, m_fc4 = 0, m_ec4 = 0;
    bit          gaps_on = 1'b1;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] fb_raw();
        logic [31:0] r;
        r = SEED;
        foreach (fb[i]) r = crc_upd(r, fb[i]);
        return r;
    endfunction

    task automatic load_ascii_123456789();
        logic [7:0] c;
        fb.delete();
        for (int i = 1; i <= 9; i++) begin
            c = 8'h30 + 8'(i);
            fb.push_back(c);
        end
    endtask

    // Pop and compare any result handed over at the coming rising edge.
    task automatic sb_sample();
        logic [33:0] e;
        if (ov4 && ordy4) begin
            n_vec++;
            if (exp4_q.size() == 0) begin
                n_err++;
                $display("FAIL sb4_unexpected: got crc=%h match=%b perr=%b, required no result", crc4, cm4, pe4);
            end else begin
                e = exp4_q.pop_front();
                if ({crc4, cm4, pe4} !== e) begin
                    n_err++;
                    $display("FAIL sb4_result: got crc=%h match=%b perr=%b, required crc=%h match=%b perr=%b",
                             crc4, cm4, pe4, e[33:2], e[1], e[0]);
                end
            end
        end
        if (ov1 && ordy1) begin
            n_vec++;
            if (exp1_q.size() == 0) begin
                n_err++;
                $display("FAIL sb1_unexpected: got crc=%h match=%b perr=%b, required no result", crc1, cm1, pe1);
            end else begin
                e = exp1_q.pop_front();
                if ({crc1, cm1, pe1} !== e) begin
                    n_err++;
                    $display("FAIL sb1_result: got crc=%h match=%b perr=%b, required crc=%h match=%b perr=%b",
                             crc1, cm1, pe1, e[33:2], e[1], e[0]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic bump4(input logic mode, input logic match);
        m_fc4 = (m_fc4 < MAX4) ? m_fc4 + 1 : MAX4;
        if (mode && !match) m_ec4 = (m_ec4 < MAX4) ? m_ec4 + 1 : MAX4;
    endtask

    // ---------------- drivers ----------------
    task automatic beat4(input logic [31:0] d, input logic [3:0] k, input logic l, input logic m);
        bit acc;
        acc = 1'b0;
        v4 = 1'b1; d4 = d; k4 = k; l4 = l; m4 = m;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = rdy4;
            sb_sample();
            @(posedge clk);
            #1;
        end
        v4 = 1'b0; l4 = 1'b0; d4 = $urandom; k4 = 4'($urandom); m4 = 1'($urandom);
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL beat4_accept: got in_ready low for 40 cycles, required acceptance");
        end
    endtask

    task automatic beat1(input logic [7:0] d, input logic l, input logic m);
        bit acc;
        acc = 1'b0;
        v1 = 1'b1; d1 = d; l1 = l; m1 = m;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = rdy1;
            sb_sample();
            @(posedge clk);
            #1;
        end
        v1 = 1'b0; l1 = 1'b0; d1 = 8'($urandom); m1 = 1'($urandom);
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL beat1_accept: got in_ready low for 40 cycles, required acceptance");
        end
    endtask

    // Sends fb on u4; junk keep on non-last beats and a wandering check_mode
    // after the first beat must both be ignored by the engine.
    task automatic send4(input logic mode);
        logic [31:0] raw, d;
        logic [3:0]  k;
        logic        match;
        int          n, nb;
        n     = fb.size();
        nb    = (n + 3) / 4;
        raw   = fb_raw();
        match = mode && (raw == RESIDUE);
        exp4_q.push_back({raw ^ SEED, match, 1'b0});
        bump4(mode, match);
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            k = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4*b + j < n) begin
                    d[8*j +: 8] = fb[4*b + j];
                    k[j] = 1'b1;
                end
            end
            if (b != nb - 1) k = 4'($urandom);
            beat4(d, k, b == nb - 1, (b == 0) ? mode : 1'($urandom));
            if (gaps_on && b != nb - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic send1(input logic mode);
        logic [31:0] raw;
        logic        match;
        int          n;
        n     = fb.size();
        raw   = fb_raw();
        match = mode && (raw == RESIDUE);
        exp1_q.push_back({raw ^ SEED, match, 1'b0});
        m_fc1++;
        if (mode && !match) m_ec1++;
        for (int b = 0; b < n; b++) begin
            beat1(fb[b], b == n - 1, (b == 0) ? mode : 1'($urandom));
            if (gaps_on && b != n - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && (exp1_q.size() != 0 || exp4_q.size() != 0); t++) tick();
        n_vec++;
        if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d results outstanding, required 0/0", exp1_q.size(), exp4_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({rdy1, rdy4} !== 2'b11) begin
            n_err++; $display("FAIL reset_in_ready: got %b, required 11", {rdy1, rdy4});
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ov1, cm1, pe1, crc1, fc1, ec1, st1} !== '0) begin
            n_err++;
            $display("FAIL reset_u1: got ov=%b crc=%h m=%b pe=%b fc=%0d ec=%0d st=%0d, required all 0",
                     ov1, crc1, cm1, pe1, fc1, ec1, st1);
        end
        n_vec++;
        if ({ov4, cm4, pe4, crc4, fc4, ec4, st4} !== '0) begin
            n_err++;
            $display("FAIL reset_u4: got ov=%b crc=%h m=%b pe=%b fc=%0d ec=%0d st=%0d, required all 0",
                     ov4, crc4, cm4, pe4, fc4, ec4, st4);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({rdy1, rdy4} !== 2'b11) begin
            n_err++; $display("FAIL post_reset_in_ready: got %b, required 11", {rdy1, rdy4});
        end
    endtask

    task automatic test_gen_1byte();
        load_ascii_123456789();
        send1(1'b0);
        // Last beat accepted at the edge just passed: result must be up now.
        n_vec++;
        if (ov1 !== 1'b1 || crc1 !== 32'hCBF43926) begin
            n_err++; $display("FAIL gen1_check_value: got ov=%b crc=%h, required ov=1 crc=cbf43926", ov1, crc1);
        end
        n_vec++;
        if (fc1 !== 16'd1 || cm1 !== 1'b0) begin
            n_err++; $display("FAIL gen1_frame_cnt: got fc=%0d match=%b, required fc=1 match=0", fc1, cm1);
        end
        drain();
    endtask

    task automatic test_gen_4byte();
        load_ascii_123456789();
        send4(1'b0);
        n_vec++;
        if (ov4 !== 1'b1 || crc4 !== 32'hCBF43926 || pe4 !== 1'b0) begin
            n_err++; $display("FAIL gen4_check_value: got ov=%b crc=%h pe=%b, required 1/cbf43926/0", ov4, crc4, pe4);
        end
        n_vec++;
        if (fc4 !== 3'(m_fc4)) begin
            n_err++; $display("FAIL gen4_frame_cnt: got %0d, required %0d", fc4, m_fc4);
        end
        drain();
    endtask

    task automatic test_check_mode();
        load_ascii_123456789();
        fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
        send4(1'b1);
        n_vec++;
        if (cm4 !== 1'b1 || crc4 !== 32'h2144DF1C) begin
            n_err++; $display("FAIL check_good: got match=%b crc=%h, required 1/2144df1c", cm4, crc4);
        end
        fb[12] = 8'hCB ^ 8'hFF;
        send4(1'b1);
        n_vec++;
        if (cm4 !== 1'b0 || ec4 !== 3'd1) begin
            n_err++; $display("FAIL check_bad: got match=%b err_cnt=%0d, required 0/1", cm4, ec4);
        end
        drain();
    endtask

    task automatic test_illegal_keep();
        logic [3:0]  keeps [0:4];
        logic [31:0] d, raw;
        logic        perr;
        int          cnt;
        keeps[0] = 4'b0101; keeps[1] = 4'b0000; keeps[2] = 4'b0110;
        keeps[3] = 4'b0111; keeps[4] = 4'b1011;
        for (int t = 0; t < 5; t++) begin
            d   = $urandom;
            cnt = 0;
            while (cnt < 4 && keeps[t][cnt]) cnt++;
            perr = (cnt == 0) || (keeps[t] != 4'((1 << cnt) - 1));
            raw  = SEED;
            for (int j = 0; j < cnt; j++) raw = crc_upd(raw, d[8*j +: 8]);
            exp4_q.push_back({raw ^ SEED, 1'b0, perr});
            bump4(1'b0, 1'b0);
            beat4(d, keeps[t], 1'b1, 1'b0);
            n_vec++;
            if (pe4 !== perr || crc4 !== (raw ^ SEED)) begin
                n_err++;
                $display("FAIL illegal_keep_%b: got pe=%b crc=%h, required pe=%b crc=%h",
                         keeps[t], pe4, crc4, perr, raw ^ SEED);
            end
        end
        drain();
        n_vec++;
        if (fc4 !== 3'(m_fc4)) begin
            n_err++; $display("FAIL frame_cnt_saturate: got %0d, required %0d", fc4, m_fc4);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] e;
        logic [31:0] raw;
        ordy4 = 1'b0;
        fb = {8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03};
        send4(1'b0);
        e = exp4_q[0];
        // Next frame: single beat, pending while the result is not consumed.
        fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        raw = fb_raw();
        exp4_q.push_back({raw ^ SEED, 1'b0, 1'b0});
        bump4(1'b0, 1'b0);
        v4 = 1'b1; d4 = 32'hEFBEADDE; k4 = 4'hF; l4 = 1'b1; m4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (rdy4 !== 1'b0 || ov4 !== 1'b1 || {crc4, cm4, pe4} !== e) begin
                n_err++;
                $display("FAIL backpressure_hold_%0d: got rdy=%b ov=%b crc=%h, required rdy=0 ov=1 crc=%h",
                         c, rdy4, ov4, crc4, e[33:2]);
            end
            @(posedge clk);
            #1;
        end
        ordy4 = 1'b1;
        beat4(32'hEFBEADDE, 4'hF, 1'b1, 1'b0);
        n_vec++;
        if (ov4 !== 1'b1 || crc4 !== (raw ^ SEED)) begin
            n_err++; $display("FAIL backpressure_next: got ov=%b crc=%h, required ov=1 crc=%h", ov4, crc4, raw ^ SEED);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic mode;
        int   len;
        gaps_on = 1'b0;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 11);
            fb.delete();
            for (int j = 0; j < len; j++) fb.push_back(8'($urandom));
            mode = 1'($urandom);
            send4(mode);
            fb.delete();
            for (int j = 0; j < len; j++) fb.push_back(8'($urandom));
            send1(mode);
        end
        gaps_on = 1'b1;
        drain();
        n_vec++;
        if (fc4 !== 3'(m_fc4) || ec4 !== 3'(m_ec4)) begin
            n_err++; $display("FAIL b2b_cnt4: got fc=%0d ec=%0d, required %0d/%0d", fc4, ec4, m_fc4, m_ec4);
        end
        n_vec++;
        if (fc1 !== 16'(m_fc1) || ec1 !== 16'(m_ec1)) begin
            n_err++; $display("FAIL b2b_cnt1: got fc=%0d ec=%0d, required %0d/%0d", fc1, ec1, m_fc1, m_ec1);
        end
    endtask

    task automatic test_err_saturate();
        for (int f = 0; f < 8; f++) begin
            fb = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            send4(1'b1);
        end
        drain();
        n_vec++;
        if (ec4 !== 3'(m_ec4) || fc4 !== 3'(m_fc4)) begin
            n_err++; $display("FAIL err_cnt_saturate: got ec=%0d fc=%0d, required %0d/%0d", ec4, fc4, m_ec4, m_fc4);
        end
    endtask

    task automatic test_reset_mid_frame();
        beat1(8'h31, 1'b0, 1'b0);
        beat1(8'h32, 1'b0, 1'b0);
        beat4(32'h44332211, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({rdy1, rdy4, ov1, ov4} !== 4'b1100 || fc1 !== 16'd0 || fc4 !== 3'd0 || ec4 !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset_state: got rdy=%b%b ov=%b%b fc1=%0d fc4=%0d ec4=%0d, required 11 00 0 0 0",
                     rdy1, rdy4, ov1, ov4, fc1, fc4, ec4);
        end
        m_fc1 = 0; m_ec1 = 0; m_fc4 = 0; m_ec4 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_ascii_123456789();
        send1(1'b0);
        n_vec++;
        if (crc1 !== 32'hCBF43926 || fc1 !== 16'd1) begin
            n_err++; $display("FAIL mid_reset_u1: got crc=%h fc=%0d, required cbf43926/1", crc1, fc1);
        end
        send4(1'b0);
        n_vec++;
        if (crc4 !== 32'hCBF43926 || fc4 !== 3'd1) begin
            n_err++; $display("FAIL mid_reset_u4: got crc=%h fc=%0d, required cbf43926/1", crc4, fc4);
        end
        drain();
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_gen_1byte();
        test_gen_4byte();
        test_check_mode();
        test_illegal_keep();
        test_backpressure();
        test_back_to_back();
        test_err_saturate();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_crc_engine.md
MAC_CRC_ENGINE -- requirements
Module: mac_crc_engine

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 1, bytes per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat valid.
REQ-006 SHALL have port in_ready, output, 1, engine can accept a beat.
REQ-007 SHALL have port in_data, input, 8*DATA_BYTES, frame bytes; byte 0 = in_data[7:0] is first on the wire.
REQ-008 SHALL have port in_keep, input, DATA_BYTES, per-byte valid; examined only on the last beat.
REQ-009 SHALL have port in_last, input, 1, final beat of the frame.
REQ-010 SHALL have port check_mode, input, 1, 0 = generate FCS, 1 = check frame that includes its FCS; sampled on the first beat of each frame.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, result consumed.
REQ-013 SHALL have port crc_out, output, 32, final CRC (register XOR 32'hFFFFFFFF).
REQ-014 SHALL have port crc_match, output, 1, check-mode pass flag; 0 in generate mode.
REQ-015 SHALL have port protocol_err, output, 1, last beat had an illegal in_keep.
REQ-016 SHALL have port frame_cnt, output, CNT_W, completed frames.
REQ-017 SHALL have port crc_err_cnt, output, CNT_W, check-mode frames with crc_match = 0.

Function
REQ-018 SHALL compute Ethernet CRC-32: reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, bits LSB first, final XOR 32'hFFFFFFFF.
REQ-019 SHALL process all DATA_BYTES bytes of an accepted beat in one cycle, byte 0 first; no internal stall.
REQ-020 SHALL accept a beat when in_valid && in_ready.
REQ-021 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-022 SHALL use the FSM IDLE -> ACCUM on an accepted non-last beat; IDLE or ACCUM -> DONE on an accepted last beat; DONE -> IDLE, or DONE -> ACCUM/DONE when a new beat is accepted in the same cycle that out_ready is high.
REQ-023 SHALL ignore in_keep on non-last beats; all bytes count.
REQ-024 SHALL include, on the last beat, bytes 0..k-1 where in_keep is contiguous ones from bit 0 (k >= 1).
REQ-025 SHALL treat a last-beat in_keep of zero or non-contiguous as illegal: include only the leading contiguous ones (none if bit 0 is 0), and set protocol_err with the result.
REQ-026 SHALL assert out_valid the cycle after the last beat is accepted (latency 1); crc_out, crc_match and protocol_err are registered with it.
REQ-027 SHALL hold out_valid and all result outputs stable until out_valid && out_ready.
REQ-028 SHALL set crc_match = 1 in check mode when the raw register equals residue 32'hDEBB20E3 (crc_out = 32'h2144DF1C).
REQ-029 SHALL re-seed the register to 32'hFFFFFFFF on the cycle after each last beat, so back-to-back frames need no idle cycle.
REQ-030 SHALL increment frame_cnt when a result is produced.
REQ-031 SHALL increment crc_err_cnt when a check-mode result has crc_match = 0.
REQ-032 SHALL saturate both counters at all-ones; they never wrap.
REQ-033 SHALL use the check_mode value latched at frame start for the whole frame; changes mid-frame have no effect.
REQ-034 SHALL not expose a partial CRC when in_valid is idle mid-frame; the register holds.

Reset
REQ-035 SHALL, while rst is high, asynchronously drive out_valid = 0, crc_out = 0, crc_match = 0, protocol_err = 0, frame_cnt = 0, crc_err_cnt = 0, register = 32'hFFFFFFFF, FSM = IDLE.
REQ-036 SHALL discard any frame in progress on reset mid-frame; the first beat after reset starts a new frame.
REQ-037 SHALL have in_ready = 1 while rst is high and after it deasserts.

Verification
REQ-038 SHALL be verified with DATA_BYTES = 1: ASCII "123456789" in generate mode -> crc_out = 32'hCBF43926, out_valid one cycle after the last byte, frame_cnt = 1.
REQ-039 SHALL be verified with DATA_BYTES = 4: the same 9 bytes in 3 beats, last in_keep = 4'b0001 -> crc_out = 32'hCBF43926.
REQ-040 SHALL be verified in check mode: "123456789" followed by bytes 26 39 F4 CB -> crc_match = 1, crc_out = 32'h2144DF1C; with the final byte flipped -> crc_match = 0, crc_err_cnt increments.
REQ-041 SHALL be verified under backpressure: out_ready low for 5 cycles with the next frame pending -> in_ready = 0, result stable, no beat lost; back-to-back frames at out_ready = 1 -> one result per frame.
REQ-042 SHALL be verified with reset mid-frame: rst pulsed after 2 bytes, then "123456789" -> crc_out = 32'hCBF43926, counters restart from 0.
REQ-043 SHALL be verified with an illegal keep: last in_keep = 4'b0101 -> protocol_err = 1 and the CRC covers byte 0 only.
